// File: rtl/nvm_pkg.sv
// nvm_pkg: shared state type and constants for the NVRAM ioctl bridge.
package nvm_pkg;
   typedef enum logic [1:0] {IDLE, PAUSE, READY, RD_WAIT} state_e;
   localparam logic [7:0] NVM_INDEX_DEF = 8'd4;
   localparam logic [7:0] FILL_BYTE = 8'hFF;
endpackage

// File: rtl/nvm_ioctl_bridge.sv
// nvm_ioctl_bridge: hps_io responder for NVRAM upload/download on one ioctl index.
// Pauses the core before touching NVRAM, stretches hps_io with ioctl_wait, flags core-side changes.
module nvm_ioctl_bridge
   import nvm_pkg::*;
#(
   parameter int         ADDR_W    = 9,
   parameter logic [7:0] NVM_INDEX = NVM_INDEX_DEF,
   parameter int         SETTLE    = 16,
   parameter int         RAM_LAT   = 1
) (
   input  logic              clk_sys,
   input  logic              RESET,
   input  logic              ioctl_download,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic              ioctl_wr,
   input  logic              ioctl_rd,
   input  logic [7:0]        ioctl_dout,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] nvm_addr,
   output logic [7:0]        nvm_din,
   output logic              nvm_we,
   output logic              nvm_rd,
   input  logic [7:0]        nvm_dout,
   output logic              core_pause_req,
   input  logic              core_nvm_wr,
   output logic              nvm_dirty
);
   state_e              state_q;
   logic [7:0]          cnt_q;
   logic [RAM_LAT:0]    sh_q;
   logic                hold_v_q, hold_ok_q, rd_ok_q;
   logic [ADDR_W-1:0]   hold_addr_q, addr_q;
   logic [7:0]          hold_data_q, wdata_q, din_q;
   logic                wait_q, we_q, rd_q, pause_q, dirty_q;
   logic                active, wr_ok, rd_ok, in_range, ending, dirty_d;

   assign active   = (ioctl_download || ioctl_upload) && ioctl_index == NVM_INDEX;
   assign wr_ok    = active && ioctl_download && ioctl_wr;
   assign rd_ok    = active && ioctl_upload && !ioctl_download && ioctl_rd;
   assign in_range = ~|ioctl_addr[24:ADDR_W];
   assign ending   = state_q != IDLE && !active;
   // a core write in the same cycle the transfer ends keeps the flag set
   assign dirty_d  = (core_nvm_wr && (state_q == IDLE || ending)) || (dirty_q && !ending);

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         hold_v_q    <= 1'b0;
         hold_ok_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
         hold_addr_q <= '0;
         addr_q      <= '0;
         hold_data_q <= '0;
         wdata_q     <= '0;
         din_q       <= FILL_BYTE;
         wait_q      <= 1'b0;
         we_q        <= 1'b0;
         rd_q        <= 1'b0;
         pause_q     <= 1'b0;
         dirty_q     <= 1'b0;
      end else begin
         we_q    <= 1'b0;
         rd_q    <= 1'b0;
         dirty_q <= dirty_d;
         if (ending) begin
            state_q  <= IDLE;
            pause_q  <= 1'b0;
            wait_q   <= 1'b0;
            hold_v_q <= 1'b0;
            we_q     <= hold_v_q && hold_ok_q;
            addr_q   <= hold_addr_q;
            wdata_q  <= hold_data_q;
         end else begin
            case (state_q)
               IDLE: if (active) begin
                  state_q     <= PAUSE;
                  pause_q     <= 1'b1;
                  wait_q      <= 1'b1;
                  cnt_q       <= '0;
                  hold_v_q    <= wr_ok;
                  hold_ok_q   <= in_range;
                  hold_addr_q <= ioctl_addr[ADDR_W-1:0];
                  hold_data_q <= ioctl_dout;
               end
               PAUSE: if (cnt_q == 8'(SETTLE - 1)) begin
                  // the held write, or one arriving right now, lands on the first READY cycle
                  we_q     <= hold_v_q ? hold_ok_q : wr_ok && in_range;
                  addr_q   <= hold_v_q ? hold_addr_q : ioctl_addr[ADDR_W-1:0];
                  wdata_q  <= hold_v_q ? hold_data_q : ioctl_dout;
                  hold_v_q <= 1'b0;
                  wait_q   <= 1'b0;
                  state_q  <= READY;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  if (wr_ok && !hold_v_q) begin
                     hold_v_q    <= 1'b1;
                     hold_ok_q   <= in_range;
                     hold_addr_q <= ioctl_addr[ADDR_W-1:0];
                     hold_data_q <= ioctl_dout;
                  end
               end
               READY: if (wr_ok) begin
                  we_q    <= in_range;
                  addr_q  <= ioctl_addr[ADDR_W-1:0];
                  wdata_q <= ioctl_dout;
               end else if (rd_ok) begin
                  state_q <= RD_WAIT;
                  wait_q  <= 1'b1;
                  rd_q    <= in_range;
                  rd_ok_q <= in_range;
                  addr_q  <= ioctl_addr[ADDR_W-1:0];
                  sh_q    <= {{RAM_LAT{1'b0}}, 1'b1};
               end
               RD_WAIT: begin
                  sh_q <= {sh_q[RAM_LAT-1:0], 1'b0};
                  if (sh_q[RAM_LAT]) begin
                     din_q   <= rd_ok_q ? nvm_dout : FILL_BYTE;
                     wait_q  <= 1'b0;
                     state_q <= READY;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ioctl_din      = din_q;
   assign ioctl_wait     = wait_q;
   assign nvm_addr       = addr_q;
   assign nvm_din        = wdata_q;
   assign nvm_we         = we_q;
   assign nvm_rd         = rd_q;
   assign core_pause_req = pause_q;
   assign nvm_dirty      = dirty_q;
endmodule

// File: tb/tb_nvm_ioctl_bridge.sv
// tb_nvm_ioctl_bridge: directed and randomized transfers checked each cycle against a timeline model.
module tb_nvm_ioctl_bridge;
   localparam int SETTLE = 16;
   localparam int RAM_LAT = 1;

   logic        clk_sys = 1'b0;
   logic        RESET = 1'b1;
   logic        ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0, ioctl_rd = 1'b0;
   logic        core_nvm_wr = 1'b0;
   logic [7:0]  ioctl_index = 8'd0, ioctl_dout = 8'd0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  nvm_dout;
   logic [7:0]  ioctl_din, nvm_din;
   logic [8:0]  nvm_addr;
   logic        ioctl_wait, nvm_we, nvm_rd, core_pause_req, nvm_dirty;

   always #5 clk_sys = ~clk_sys;

   nvm_ioctl_bridge #(.ADDR_W(9), .NVM_INDEX(8'd4), .SETTLE(SETTLE), .RAM_LAT(RAM_LAT)) dut (
      .clk_sys(clk_sys), .RESET(RESET),
      .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_addr(ioctl_addr), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_dout(ioctl_dout),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
      .nvm_addr(nvm_addr), .nvm_din(nvm_din), .nvm_we(nvm_we), .nvm_rd(nvm_rd), .nvm_dout(nvm_dout),
      .core_pause_req(core_pause_req), .core_nvm_wr(core_nvm_wr), .nvm_dirty(nvm_dirty)
   );

   // NVRAM behind the bridge, one cycle read latency
   logic [7:0] tb_ram [512];
   always @(posedge clk_sys) begin
      if (nvm_we) tb_ram[nvm_addr] <= nvm_din;
      if (nvm_rd) nvm_dout <= tb_ram[nvm_addr];
   end

   logic [7:0]  mem [512];
   int          cyc, checks, errors;
   bit          on, held, reading, rd_inr;
   int          t_ready, t_done;
   logic [24:0] held_a;
   logic [8:0]  rd_a, e_addr;
   logic [7:0]  held_d, e_din, e_idin;
   bit          e_pause, e_wait, e_we, e_rd, e_dirty;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      on = 0; held = 0; reading = 0;
      e_pause = 0; e_wait = 0; e_we = 0; e_rd = 0; e_dirty = 0; e_idin = 8'hFF;
   endtask

   task automatic model_commit(input logic [24:0] a, input logic [7:0] d);
      e_we = a < 25'd512;
      e_addr = a[8:0];
      e_din = d;
      if (e_we) mem[a[8:0]] = d;
   endtask

   // predicts outputs visible after the coming clock edge from this cycle's inputs
   task automatic model_step();
      bit act, wr_d, rd_u, inr;
      act  = (ioctl_download || ioctl_upload) && ioctl_index == 8'd4;
      wr_d = ioctl_wr && ioctl_download;
      rd_u = ioctl_rd && ioctl_upload && !ioctl_download;
      inr  = ioctl_addr < 25'd512;
      e_we = 0; e_rd = 0;
      if (!on) begin
         if (core_nvm_wr) e_dirty = 1;
         if (act) begin
            on = 1; t_ready = cyc + SETTLE + 1;
            held = wr_d; held_a = ioctl_addr; held_d = ioctl_dout;
            e_pause = 1; e_wait = 1;
         end
      end else if (!act) begin
         if (held) model_commit(held_a, held_d);
         on = 0; held = 0; reading = 0;
         e_pause = 0; e_wait = 0; e_dirty = core_nvm_wr;
      end else if (cyc < t_ready - 1) begin
         if (wr_d && !held) begin
            held = 1; held_a = ioctl_addr; held_d = ioctl_dout;
         end
      end else if (cyc == t_ready - 1) begin
         if (held) model_commit(held_a, held_d);
         else if (wr_d) model_commit(ioctl_addr, ioctl_dout);
         held = 0; e_wait = 0;
      end else if (reading) begin
         if (cyc == t_done) begin
            e_idin = rd_inr ? mem[rd_a] : 8'hFF;
            e_wait = 0; reading = 0;
         end
      end else if (wr_d) begin
         model_commit(ioctl_addr, ioctl_dout);
      end else if (rd_u) begin
         reading = 1; t_done = cyc + 1 + RAM_LAT;
         rd_inr = inr; rd_a = ioctl_addr[8:0];
         e_wait = 1; e_rd = inr; e_addr = ioctl_addr[8:0];
      end
   endtask

   task automatic compare();
      chk("core_pause_req", core_pause_req, e_pause);
      chk("ioctl_wait", ioctl_wait, e_wait);
      chk("nvm_we", nvm_we, e_we);
      chk("nvm_rd", nvm_rd, e_rd);
      chk("ioctl_din", ioctl_din, e_idin);
      chk("nvm_dirty", nvm_dirty, e_dirty);
      if (e_we) begin
         chk("nvm_addr_wr", nvm_addr, e_addr);
         chk("nvm_din", nvm_din, e_din);
      end
      if (e_rd) chk("nvm_addr_rd", nvm_addr, e_addr);
   endtask

   task automatic tick();
      model_step();
      cyc++;
      @(negedge clk_sys);
      compare();
      ioctl_wr = 0; ioctl_rd = 0; core_nvm_wr = 0;
   endtask

   task automatic open_xfer(input bit dl, input bit ul);
      ioctl_download = dl; ioctl_upload = ul; ioctl_index = 8'd4;
      tick();
      repeat (SETTLE) tick();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i] = 8'($urandom);
         tb_ram[i] = mem[i];
      end
      mem[5] = 8'hA7; tb_ram[5] = 8'hA7;
      model_reset();
      cyc = 0; checks = 0; errors = 0;
      repeat (3) @(negedge clk_sys);
      RESET = 0;
      compare();
      chk("reset_din", ioctl_din, 8'hFF);

      ioctl_upload = 1; ioctl_index = 8'd4;
      tick();
      chk("up_pause_c1", core_pause_req, 1);
      chk("up_wait_c1", ioctl_wait, 1);
      repeat (SETTLE - 1) tick();
      chk("up_wait_c16", ioctl_wait, 1);
      tick();
      chk("up_wait_c17", ioctl_wait, 0);
      ioctl_rd = 1; ioctl_addr = 25'h005;
      tick();
      chk("up_rd_pulse", nvm_rd, 1);
      tick(); tick();
      chk("up_din_a7", ioctl_din, 8'hA7);
      chk("up_wait_done", ioctl_wait, 0);
      ioctl_rd = 1; ioctl_addr = 25'h3FF;
      tick();
      chk("oor_no_rd", nvm_rd, 0);
      tick(); tick();
      chk("oor_rd_ff", ioctl_din, 8'hFF);

      ioctl_rd = 1; ioctl_addr = 25'h009;
      tick();
      chk("pre_reset_wait", ioctl_wait, 1);
      RESET = 1;
      #1;
      chk("rst_wait", ioctl_wait, 0);
      chk("rst_pause", core_pause_req, 0);
      chk("rst_din", ioctl_din, 8'hFF);
      model_reset();
      ioctl_upload = 0; ioctl_index = 8'd0;
      @(negedge clk_sys);
      RESET = 0;
      compare();

      ioctl_download = 1; ioctl_index = 8'd4;
      ioctl_wr = 1; ioctl_addr = 25'h000; ioctl_dout = 8'h3C;
      tick();
      repeat (SETTLE) tick();
      chk("dl_early_we", nvm_we, 1);
      chk("dl_early_addr", nvm_addr, 0);
      chk("dl_early_din", nvm_din, 8'h3C);
      ioctl_wr = 1; ioctl_addr = 25'h1F0; ioctl_dout = 8'h61;
      tick();
      chk("dl_lat1_we", nvm_we, 1);
      chk("dl_lat1_addr", nvm_addr, 9'h1F0);
      ioctl_wr = 1; ioctl_addr = 25'h200; ioctl_dout = 8'h77;
      tick();
      chk("dl_oor_we", nvm_we, 0);
      ioctl_download = 0;
      tick();
      chk("dl_end_pause", core_pause_req, 0);

      ioctl_download = 1; ioctl_index = 8'd0;
      for (int i = 0; i < 3; i++) begin
         ioctl_wr = 1; ioctl_addr = 25'(i);
         tick();
         chk("idx0_pause", core_pause_req, 0);
         chk("idx0_we", nvm_we, 0);
      end
      ioctl_download = 0;

      core_nvm_wr = 1;
      tick();
      chk("dirty_set", nvm_dirty, 1);
      open_xfer(0, 1);
      ioctl_rd = 1; ioctl_addr = 25'h000;
      core_nvm_wr = 1;
      repeat (3) tick();
      chk("dirty_in_xfer", nvm_dirty, 1);
      chk("up_after_dl", ioctl_din, 8'h3C);
      ioctl_upload = 0;
      tick();
      chk("dirty_clr", nvm_dirty, 0);
      core_nvm_wr = 1;
      tick();
      open_xfer(0, 1);
      ioctl_upload = 0; core_nvm_wr = 1;
      tick();
      chk("dirty_coincident", nvm_dirty, 1);

      open_xfer(1, 1);
      ioctl_rd = 1; ioctl_addr = 25'h003;
      tick();
      chk("both_no_rd", nvm_rd, 0);
      chk("both_no_wait", ioctl_wait, 0);
      ioctl_wr = 1; ioctl_addr = 25'h007; ioctl_dout = 8'h5A;
      tick();
      chk("both_we", nvm_we, 1);
      chk("both_din", nvm_din, 8'h5A);
      ioctl_download = 0; ioctl_upload = 0;
      tick();

      for (int s = 0; s < 40; s++) begin
         int len;
         bit dl, ul;
         dl = 1'($urandom % 2);
         ul = dl ? ($urandom % 3 == 0) : 1'b1;
         ioctl_download = dl; ioctl_upload = ul;
         ioctl_index = ($urandom % 6 == 0) ? 8'($urandom_range(0, 255)) : 8'd4;
         len = $urandom_range(5, 60);
         for (int k = 0; k < len; k++) begin
            if (ioctl_wait ? ($urandom % 6 == 0) : ($urandom % 2 == 0)) begin
               if ($urandom % 2 == 1) ioctl_wr = 1;
               else ioctl_rd = 1;
               ioctl_addr = ($urandom % 8 == 0) ? 25'($urandom_range(512, 33554431))
                                                : 25'($urandom_range(0, 511));
               ioctl_dout = 8'($urandom);
            end
            core_nvm_wr = ($urandom % 5 == 0);
            tick();
         end
         ioctl_download = 0; ioctl_upload = 0;
         core_nvm_wr = ($urandom % 3 == 0);
         tick();
         repeat ($urandom_range(0, 4)) begin
            core_nvm_wr = ($urandom % 4 == 0);
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
